// File: rtl/mux_pkg.sv
// Shared definitions for the mux scan sequencer: FSM encoding, channel
// geometry and the select-to-channel mapping used by the mux.
package mux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_e;

  // Channel index seen by the mux: 2*s0 + s1, i.e. s0 is the MSB.
  function automatic logic [CH_W-1:0] sel_to_idx(input logic [1:0] sel);
    return sel;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Up-counter that times how long a channel stays selected. It counts while
// enabled, wraps to zero after DWELL-1 and flags that terminal count.
module dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count and wrap at the terminal value.
  always_comb begin
    // NOTE: default first so every path assigns cnt_d and no latch is inferred.
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer in front of a 4:1 enabled mux. A start pulse enables the
// mux and walks channels 0..3, holding each for DWELL cycles and sampling d
// at the end of each dwell; the four samples are then published on data
// together with a one-cycle done pulse.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              d,
  output logic              s0,
  output logic              s1,
  output logic              e,
  output logic              busy,
  output logic              done,
  output logic [NUM_CH-1:0] data
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_e            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [NUM_CH-2:0] shadow_q, shadow_d;
  logic [NUM_CH-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              dwell_tc;
  logic              cnt_clr;
  logic              cnt_en;

  // The dwell count restarts from zero whenever a scan begins or is cancelled.
  assign cnt_clr = (state_q == ST_IDLE) || abort;
  assign cnt_en  = (state_q == ST_SCAN);

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (dwell_tc)
  );

  // Next-state, channel stepping and end-of-dwell sampling.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    shadow_d = shadow_q;
    data_d   = data_q;
    done_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (start && !abort) begin
        state_d = ST_SCAN;
        ch_d    = '0;
      end
    end else begin
      if (abort) begin
        state_d  = ST_IDLE;
        ch_d     = '0;
        shadow_d = '0;
      end else if (dwell_tc) begin
        if (ch_q == LAST_CH) begin
          data_d  = {d, shadow_q};
          done_d  = 1'b1;
          state_d = ST_IDLE;
          ch_d    = '0;
        end else begin
          shadow_d[sel_to_idx({s0, s1})] = d;
          ch_d = ch_q + 1'b1;
        end
      end
    end
  end

  // Sequencer registers; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      shadow_q <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      shadow_q <= shadow_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

  // Outputs come straight from flops.
  assign s0   = ch_q[1];
  assign s1   = ch_q[0];
  assign e    = (state_q == ST_SCAN);
  assign busy = (state_q == ST_SCAN);
  assign done = done_q;
  assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl driving a behavioural 4:1 enabled mux. A cycle-level
// reference model predicts outputs and pushes expected done events into a
// scoreboard queue; a negedge monitor compares the DUT against it.
module tb_mux_scan_ctrl;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst, start, abort, d;
  logic       s0, s1, e, busy, done;
  logic [3:0] data;
  logic [3:0] i_in;

  always #5 clk = ~clk;

  // The downstream mux: selected input when enabled, 0 otherwise.
  assign d = e ? i_in[{s0, s1}] : 1'b0;

  mux_scan_ctrl #(.DWELL(DWELL)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .d     (d),
    .s0    (s0),
    .s1    (s1),
    .e     (e),
    .busy  (busy),
    .done  (done),
    .data  (data)
  );

  typedef struct {
    int         cyc;
    logic [3:0] data;
  } done_t;

  done_t      exp_q[$];
  int         n      = 0;
  bit         m_scan = 1'b0;
  int         m_e0   = 0;
  logic [3:0] m_bits = '0;
  logic [3:0] m_data = '0;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", name, n, act, exp);
    end
  endtask

  // Reference model: a scan started at edge E0 samples input k at edge
  // E0 + (k+1)*DWELL and completes at E0 + 4*DWELL.
  always @(posedge clk) begin
    int k;
    n++;
    if (rst) begin
      m_scan = 1'b0;
      m_data = '0;
    end else if (m_scan) begin
      if (abort) begin
        m_scan = 1'b0;
      end else if ((n - m_e0) % DWELL == 0) begin
        k = (n - m_e0) / DWELL - 1;
        m_bits[k] = i_in[k];
        if (k == 3) begin
          m_scan = 1'b0;
          m_data = m_bits;
          exp_q.push_back('{n, m_bits});
        end
      end
    end else if (start && !abort) begin
      m_scan = 1'b1;
      m_e0   = n;
    end
  end

  // Monitor: compare registered outputs half a cycle after each edge.
  always @(negedge clk) begin
    logic [1:0] esel;
    logic       exp_done;
    done_t      x;
    if (n > 0) begin
      esel = m_scan ? 2'((n - m_e0) / DWELL) : 2'b00;
      check("busy_e_sel_data", 32'({busy, e, s0, s1, data}),
            32'({m_scan, m_scan, esel, m_data}));
      exp_done = (exp_q.size() > 0) && (exp_q[0].cyc == n);
      check("done", 32'(done), 32'(exp_done));
      if (exp_done) begin
        x = exp_q.pop_front();
        check("done_data", 32'(data), 32'(x.data));
      end
    end
  end

  task automatic step(input int c = 1);
    repeat (c) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int budget);
    for (int t = 0; t < budget && !done; t++) step();
    check("done_within_budget", 32'(done), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; i_in = '0;
    step(3);
    rst = 1'b0;
    step(2);

    // Single scan of a fixed pattern.
    i_in = 4'b0101; start = 1'b1; step(); start = 1'b0; step(20);

    // Back-to-back scans, second start issued in the done cycle.
    i_in = 4'b1000; start = 1'b1; step(); start = 1'b0;
    wait_done(40);
    i_in = 4'b0001; start = 1'b1; step(); start = 1'b0; step(20);

    // Abort at edge 6 of a scan.
    i_in = 4'($urandom); start = 1'b1; step(); start = 1'b0;
    step(5); abort = 1'b1; step(); abort = 1'b0; step(20);

    // Extra starts at edges 3 and 9 of a running scan.
    i_in = 4'($urandom); start = 1'b1; step(); start = 1'b0;
    step(2); start = 1'b1; step(); start = 1'b0;
    step(5); start = 1'b1; step(); start = 1'b0; step(20);

    // Reset at edge 10 of a scan.
    i_in = 4'($urandom); start = 1'b1; step(); start = 1'b0;
    step(9); rst = 1'b1; step(); rst = 1'b0; step(20);

    // start and abort together while idle.
    start = 1'b1; abort = 1'b1;
    for (int t = 0; t < 3; t++) begin i_in = 4'($urandom); step(); end
    start = 1'b0; abort = 1'b0; step(5);

    // Random traffic with inputs changing every cycle.
    for (int t = 0; t < 3000; t++) begin
      i_in  = 4'($urandom);
      start = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 59) == 0);
      rst   = ($urandom_range(0, 299) == 0);
      step();
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    step(25);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
